branch_seq: RTL and testbench

BRANCH_SEQ -- requirements
Module: branch_seq

---
 rtl/branch_seq.sv | 71 +++++++
 tb/tb_branch_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/branch_seq.sv
// branch_seq: control sequencer for a conditional branch (steps T3..T6) with a taken-branch counter.
// Define BRANCH_SEQ_EARLY_EXIT_EN to retire not-taken branches directly from T3.
module branch_seq (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        start,
    input  logic        hold,
    input  logic        con_ff,
    output logic        gra,
    output logic        r_out,
    output logic        con_en,
    output logic        pc_out,
    output logic        y_in,
    output logic        c_out,
    output logic        alu_add,
    output logic        z_in,
    output logic        zlow_out,
    output logic        pc_in,
    output logic        busy,
    output logic        done,
    output logic        con_q,
    output logic [15:0] taken_cnt
);
    typedef enum logic [2:0] {IDLE, T3, T4, T5, T6, DONE} seqState;
    seqState state, nextState;

    always_comb begin
        nextState = state;
        if (!hold)
            case (state)
                IDLE:    nextState = start ? T3 : IDLE;
`ifdef BRANCH_SEQ_EARLY_EXIT_EN
                T3:      nextState = con_ff ? T4 : DONE;
`else
                T3:      nextState = T4;
`endif
                T4:      nextState = T5;
                T5:      nextState = T6;
                T6:      nextState = DONE;
                default: nextState = IDLE;
            endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state     <= IDLE;
            con_q     <= 1'b0;
            taken_cnt <= 16'd0;
        end else begin
            state <= nextState;
            if (state == T3 && !hold)
                con_q <= con_ff;
            // counter wraps naturally at 16 bits
            if (state == T6 && !hold && con_q)
                taken_cnt <= taken_cnt + 16'd1;
        end
    end

    assign gra      = state == T3;
    assign r_out    = state == T3;
    assign con_en   = state == T3;
    assign pc_out   = state == T4;
    assign y_in     = state == T4;
    assign c_out    = state == T5;
    assign alu_add  = state == T5;
    assign z_in     = state == T5;
    assign zlow_out = state == T6;
    assign pc_in    = state == T6 && con_q;
    assign busy     = state == T3 || state == T4 || state == T5 || state == T6;
    assign done     = state == DONE;
endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: directed bench for branch_seq with a taken-count scoreboard.
module tb_branch_seq;
    logic clock = 1'b0, clear_n = 1'b0, start = 1'b0, hold = 1'b0, con_ff = 1'b0;
    logic gra, r_out, con_en, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in, busy, done, con_q;
    logic [15:0] taken_cnt;
    logic [15:0] ctl;
    logic [15:0] modelCnt = 16'd0;
    logic [15:0] sb[$];
    int checks = 0, errors = 0;

    // {gra,r_out,con_en,pc_out,y_in,c_out,alu_add,z_in,zlow_out,pc_in,busy,done}
    localparam logic [15:0] VI  = 16'b0000_0000_0000_0000;
    localparam logic [15:0] V3  = 16'b0000_1110_0000_0010;
    localparam logic [15:0] V4  = 16'b0000_0001_1000_0010;
    localparam logic [15:0] V5  = 16'b0000_0000_0111_0010;
    localparam logic [15:0] V6  = 16'b0000_0000_0000_1010;
    localparam logic [15:0] V6T = 16'b0000_0000_0000_1110;
    localparam logic [15:0] VD  = 16'b0000_0000_0000_0001;

    assign ctl = {4'd0, gra, r_out, con_en, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in, busy, done};

    branch_seq dut (
        .clock(clock), .clear_n(clear_n), .start(start), .hold(hold), .con_ff(con_ff),
        .gra(gra), .r_out(r_out), .con_en(con_en), .pc_out(pc_out), .y_in(y_in),
        .c_out(c_out), .alu_add(alu_add), .z_in(z_in), .zlow_out(zlow_out), .pc_in(pc_in),
        .busy(busy), .done(done), .con_q(con_q), .taken_cnt(taken_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic issue(input logic cf);
        con_ff = cf;
        start = 1'b1;
        modelCnt = modelCnt + {15'd0, cf};
        sb.push_back(modelCnt);
        step();
        start = 1'b0;
    endtask

    task automatic runChecked(input string tag, input logic cf);
        logic [15:0] seq[$];
        seq = {V3, V4, V5, cf ? V6T : V6, VD};
`ifdef BRANCH_SEQ_EARLY_EXIT_EN
        if (!cf) seq = {V3, VD};
`endif
        issue(cf);
        foreach (seq[i]) begin
            chk($sformatf("%s_cyc%0d", tag, i + 1), ctl, seq[i]);
            if (i < seq.size() - 1) step();
        end
        chk({tag, "_conq"}, {15'd0, con_q}, {15'd0, cf});
        if (sb.size() != 0) chk({tag, "_cnt"}, taken_cnt, sb.pop_front());
        step();
        chk({tag, "_idle"}, ctl, VI);
    endtask

    initial begin
        step();
        #2;
        chk("rst_ctl", ctl, VI);
        chk("rst_cnt", taken_cnt, 16'd0);
        chk("rst_conq", {15'd0, con_q}, 16'd0);
        clear_n = 1'b1;
        step();
        chk("idle_nostart", ctl, VI);

        runChecked("taken1", 1'b1);
        runChecked("nottaken", 1'b0);
        runChecked("taken2", 1'b1);

        // start with hold in IDLE stays pending while start remains high
        con_ff = 1'b1;
        start = 1'b1;
        hold = 1'b1;
        step();
        chk("holdidle1", ctl, VI);
        step();
        chk("holdidle2", ctl, VI);
        hold = 1'b0;
        runChecked("pending", 1'b1);

        // hold for three cycles in T5, with start pulses that must be ignored
        issue(1'b1);
        chk("hold_t3", ctl, V3);
        step();
        chk("hold_t4", ctl, V4);
        step();
        chk("hold_t5", ctl, V5);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = i[0];
            step();
            chk($sformatf("hold_t5_%0d", i), ctl, V5);
        end
        hold = 1'b0;
        start = 1'b1;
        step();
        chk("hold_t6", ctl, V6T);
        step();
        chk("hold_done", ctl, VD);
        if (sb.size() != 0) chk("hold_cnt", taken_cnt, sb.pop_front());
        step();
        chk("hold_ignored", ctl, VI);
        start = 1'b0;
        step();
        chk("hold_idle", ctl, VI);

        // asynchronous reset mid-T5
        issue(1'b1);
        step();
        step();
        chk("arst_t5", ctl, V5);
        #2 clear_n = 1'b0;
        #1;
        chk("arst_ctl", ctl, VI);
        chk("arst_cnt", taken_cnt, 16'd0);
        chk("arst_conq", {15'd0, con_q}, 16'd0);
        sb.delete();
        modelCnt = 16'd0;
        step();
        clear_n = 1'b1;
        step();
        chk("arst_idle", ctl, VI);
        runChecked("postrst", 1'b1);

        // preload near the top of the range, then wrap
        force dut.taken_cnt = 16'hFFFE;
        #1 release dut.taken_cnt;
        modelCnt = 16'hFFFE;
        runChecked("tofff", 1'b1);
        runChecked("wrap", 1'b1);
        runChecked("afterwrap_nt", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
